// File: rtl/cov_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cov_pkg
// Purpose  : Shared types for the covariance-array controller. Holds the
//            controller state encoding, the finish-flag token carried through
//            the array latency, and the array drain latency helper.
// Revision : 1.0 - initial release
// ============================================================================
package cov_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2
    } cov_state_t;

    // One token per arr_finish pulse. A discard token marks an abort flush
    // whose array results must not be reported.
    typedef struct packed {
        logic valid;
        logic discard;
    } cov_token_t;

    localparam int STALL_W = 16;

    // Cycles from arr_finish to valid PE results: the flag ripples through
    // 2*NUM_ANT-1 PE stages, each PE_LAT deep.
    function automatic int drain_cycles(input int pe_lat, input int num_ant);
        return pe_lat * (2 * num_ant - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cov_flag_delay.sv
`default_nettype none
// ============================================================================
// Module   : cov_flag_delay
// Purpose  : DEPTH-deep shift register of finish tokens. A token written at
//            tok_i appears at tok_o exactly DEPTH cycles later. Several tokens
//            may be in flight at once (back-to-back frames).
// Ports    : clk, rst_n     clock, async active-low reset (clears the line)
//            tok_i          token entering the line
//            tok_o          token leaving the line this cycle
//            pending_o      some token is still inside, not counting tok_o
// Revision : 1.0 - initial release
// ============================================================================
module cov_flag_delay
    import cov_pkg::*;
#(
    parameter int DEPTH = 14
) (
    input  logic       clk,
    input  logic       rst_n,
    input  cov_token_t tok_i,
    output cov_token_t tok_o,
    output logic       pending_o
);

    cov_token_t stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q[0] <= tok_i;
            for (int k = 1; k < DEPTH; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign tok_o = stage_q[DEPTH-1];

    // The final stage is excluded: it is the token leaving right now.
    always_comb begin
        pending_o = 1'b0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            pending_o = pending_o | stage_q[k].valid;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cov_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cov_array_ctrl
// Purpose  : Sequencer for the NUM_ANT x NUM_ANT covariance PE array. Accepts
//            antenna snapshots, feeds the array every clock (zeros on
//            bubbles), inserts the frame-end finish flag after
//            2^SAMPLES_BITS samples and pulses res_capture when the array
//            results for that frame are valid.
// Ports    : start_i/abort_i        run control pulses
//            cfg_frames_i           frames per run (0 behaves as 1)
//            snap_valid_i/ready_o   snapshot handshake
//            snap_q_i/snap_i_i      snapshot, antenna 0 in LSBs
//            arr_q_o/arr_i_o        registered array feed
//            arr_finish_o           finish flag aligned with the feed
//            res_capture_o          array results valid (1-cycle pulse)
//            frame_done_o           frame completed (1-cycle pulse)
//            busy_o                 run in progress
//            aborted_o              abort flush complete (1-cycle pulse)
//            stall_cnt_o            ACCUM cycles without snap_valid
// Options  : COV_STALL_CNT_EN - adds stall_cnt_o and its counter.
// Revision : 1.0 - initial release
// ============================================================================
module cov_array_ctrl
    import cov_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_ANT      = 4,
    parameter int SAMPLES_BITS = 4,
    parameter int PE_LAT       = 2,
    parameter int FRAME_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic                          abort_i,
    input  logic [FRAME_W-1:0]            cfg_frames_i,
    input  logic                          snap_valid_i,
    output logic                          snap_ready_o,
    input  logic [NUM_ANT*DATA_WIDTH-1:0] snap_q_i,
    input  logic [NUM_ANT*DATA_WIDTH-1:0] snap_i_i,
    output logic [NUM_ANT*DATA_WIDTH-1:0] arr_q_o,
    output logic [NUM_ANT*DATA_WIDTH-1:0] arr_i_o,
    output logic                          arr_finish_o,
    output logic                          res_capture_o,
    output logic                          frame_done_o,
    output logic                          busy_o,
    output logic                          aborted_o
`ifdef COV_STALL_CNT_EN
   ,output logic [STALL_W-1:0]            stall_cnt_o
`endif
);

    localparam int DW    = NUM_ANT * DATA_WIDTH;
    localparam int DRAIN = drain_cycles(PE_LAT, NUM_ANT);
    localparam logic [SAMPLES_BITS-1:0] LAST_SAMPLE = '1;

    cov_state_t              state_q, state_d;
    logic [FRAME_W-1:0]      frames_left_q, frames_left_d;
    logic [SAMPLES_BITS-1:0] sample_cnt_q, sample_cnt_d;
    logic [DW-1:0]           arr_q_q, arr_q_d;
    logic [DW-1:0]           arr_i_q, arr_i_d;
    logic                    finish_q, finish_d;
    logic                    discard_q, discard_d;

    logic                    hs;
    logic                    last_hs;
    cov_token_t              tok_in;
    cov_token_t              tok_out;
    logic                    tok_pending;

    assign hs      = (state_q == ACCUM) && snap_valid_i;
    assign last_hs = hs && (sample_cnt_q == LAST_SAMPLE);

    always_comb begin
        state_d       = state_q;
        frames_left_d = frames_left_q;
        sample_cnt_d  = sample_cnt_q;
        arr_q_d       = '0;
        arr_i_d       = '0;
        finish_d      = 1'b0;
        discard_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d       = ACCUM;
                    frames_left_d = (cfg_frames_i == '0) ? FRAME_W'(1) : cfg_frames_i;
                    sample_cnt_d  = '0;
                end
            end
            ACCUM: begin
                if (abort_i && !last_hs) begin
                    // Zero feed with finish flag clears the PE accumulators;
                    // the token is tagged so its results are never reported.
                    finish_d  = 1'b1;
                    discard_d = 1'b1;
                    state_d   = FLUSH;
                end else if (hs) begin
                    arr_q_d      = snap_q_i;
                    arr_i_d      = snap_i_i;
                    sample_cnt_d = sample_cnt_q + SAMPLES_BITS'(1);
                    if (last_hs) begin
                        // An abort coinciding with the final sample lets the
                        // frame complete normally and simply ends the run.
                        finish_d      = 1'b1;
                        frames_left_d = frames_left_q - FRAME_W'(1);
                        if ((frames_left_q == FRAME_W'(1)) || abort_i) begin
                            state_d = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                // Leave once nothing remains behind the token exiting now.
                if (!finish_q && !tok_pending) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            frames_left_q <= '0;
            sample_cnt_q  <= '0;
            arr_q_q       <= '0;
            arr_i_q       <= '0;
            finish_q      <= 1'b0;
            discard_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            frames_left_q <= frames_left_d;
            sample_cnt_q  <= sample_cnt_d;
            arr_q_q       <= arr_q_d;
            arr_i_q       <= arr_i_d;
            finish_q      <= finish_d;
            discard_q     <= discard_d;
        end
    end

    assign tok_in = '{valid: finish_q, discard: discard_q};

    cov_flag_delay #(
        .DEPTH (DRAIN)
    ) u_flag_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .tok_i     (tok_in),
        .tok_o     (tok_out),
        .pending_o (tok_pending)
    );

    assign snap_ready_o  = (state_q == ACCUM);
    assign busy_o        = (state_q != IDLE);
    assign arr_q_o       = arr_q_q;
    assign arr_i_o       = arr_i_q;
    assign arr_finish_o  = finish_q;
    assign res_capture_o = tok_out.valid && !tok_out.discard;
    assign frame_done_o  = tok_out.valid && !tok_out.discard;
    assign aborted_o     = tok_out.valid && tok_out.discard;

`ifdef COV_STALL_CNT_EN
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == IDLE) && start_i) begin
            stall_cnt_d = '0;
        end else if ((state_q == ACCUM) && !snap_valid_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cov_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cov_array_ctrl
// Purpose  : Self-checking bench for cov_array_ctrl. A cycle-level reference
//            model (event schedule of result/abort pulses keyed by cycle)
//            predicts every output; directed runs pin latency, frame counts
//            and the antenna-0 diagonal result of a simple array model.
// Options  : COV_STALL_CNT_EN - also checks stall_cnt_o.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cov_array_ctrl;

    localparam int DW_S  = 16;
    localparam int NA    = 4;
    localparam int SB    = 4;
    localparam int PL    = 2;
    localparam int FW    = 16;
    localparam int DW    = NA * DW_S;
    localparam int NSAMP = 1 << SB;
    localparam int DRAIN = PL * (2 * NA - 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [FW-1:0] cfg = '0;
    logic          snap_valid = 1'b0;
    logic [DW-1:0] snap_q = '0;
    logic [DW-1:0] snap_i = '0;
    logic          snap_ready_o, arr_finish_o, res_capture_o, frame_done_o, busy_o, aborted_o;
    logic [DW-1:0] arr_q_o, arr_i_o;
`ifdef COV_STALL_CNT_EN
    logic [15:0]   stall_cnt_o;
`endif

    cov_array_ctrl #(
        .DATA_WIDTH   (DW_S),
        .NUM_ANT      (NA),
        .SAMPLES_BITS (SB),
        .PE_LAT       (PL),
        .FRAME_W      (FW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .abort_i       (abort),
        .cfg_frames_i  (cfg),
        .snap_valid_i  (snap_valid),
        .snap_ready_o  (snap_ready_o),
        .snap_q_i      (snap_q),
        .snap_i_i      (snap_i),
        .arr_q_o       (arr_q_o),
        .arr_i_o       (arr_i_o),
        .arr_finish_o  (arr_finish_o),
        .res_capture_o (res_capture_o),
        .frame_done_o  (frame_done_o),
        .busy_o        (busy_o),
        .aborted_o     (aborted_o)
`ifdef COV_STALL_CNT_EN
       ,.stall_cnt_o   (stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    int            cyc = 0;
    int            m_mode = 0;      // 0 idle, 1 accumulating, 2 flushing
    int            m_cnt = 0;
    int            m_frames = 0;
    int            m_last = 0;      // cycle the newest token leaves the array
    int            m_stall = 0;
    logic [DW-1:0] e_q = '0, e_i = '0;
    logic          e_fin = 1'b0;
    bit            cap_ev [int];
    bit            abt_ev [int];

    // ---------------- observation / array model ----------------
    int fin_cyc = 0, cap_cyc = 0, abt_cyc = 0;
    int n_fin = 0, n_cap = 0, n_fd = 0, n_abt = 0;
    int fin_times [$];
    int acc = 0;
    int diag_q [$];
    bit chk_diag = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ctrl", 128'({busy_o, snap_ready_o, arr_finish_o, res_capture_o,
                                  frame_done_o, aborted_o}), 128'(0));
            chk("rst_arr", {arr_q_o, arr_i_o}, 128'(0));
            m_mode = 0; m_cnt = 0; m_frames = 0; m_last = 0; m_stall = 0;
            e_q = '0; e_i = '0; e_fin = 1'b0;
            cap_ev.delete(); abt_ev.delete();
            diag_q.delete(); acc = 0;
        end else begin
            chk("busy",        128'(busy_o),        128'(m_mode != 0));
            chk("snap_ready",  128'(snap_ready_o),  128'(m_mode == 1));
            chk("arr_q",       128'(arr_q_o),       128'(e_q));
            chk("arr_i",       128'(arr_i_o),       128'(e_i));
            chk("arr_finish",  128'(arr_finish_o),  128'(e_fin));
            chk("res_capture", 128'(res_capture_o), 128'(cap_ev.exists(cyc)));
            chk("frame_done",  128'(frame_done_o),  128'(cap_ev.exists(cyc)));
            chk("aborted",     128'(aborted_o),     128'(abt_ev.exists(cyc)));
`ifdef COV_STALL_CNT_EN
            chk("stall_cnt",   128'(stall_cnt_o),   128'(m_stall));
`endif
            // Array model: antenna-0 power, averaged over the frame.
            begin
                int a0q, a0i, sum;
                a0q = int'($signed(arr_q_o[DW_S-1:0]));
                a0i = int'($signed(arr_i_o[DW_S-1:0]));
                sum = acc + a0q * a0q + a0i * a0i;
                if (res_capture_o || aborted_o) begin
                    if (diag_q.size() == 0) begin
                        chk_int("diag_pending", 0, 1);
                    end else begin
                        int d;
                        d = diag_q.pop_front();
                        if (res_capture_o && chk_diag) chk_int("diag_result", d, 32);
                    end
                end
                if (arr_finish_o) begin
                    diag_q.push_back(sum >>> SB);
                    acc = 0;
                end else begin
                    acc = sum;
                end
            end
            if (arr_finish_o) begin fin_cyc = cyc; n_fin++; fin_times.push_back(cyc); end
            if (res_capture_o) begin cap_cyc = cyc; n_cap++; end
            if (frame_done_o) n_fd++;
            if (aborted_o) begin abt_cyc = cyc; n_abt++; end

            // Predict the next cycle from this cycle's inputs.
            e_q = '0; e_i = '0; e_fin = 1'b0;
            case (m_mode)
                0: if (start) begin
                    m_mode = 1; m_cnt = 0; m_stall = 0;
                    m_frames = (cfg == 0) ? 1 : int'(cfg);
                end
                1: begin
                    bit last_s;
                    last_s = snap_valid && (m_cnt == NSAMP - 1);
                    if (!snap_valid && m_stall < 65535) m_stall++;
                    if (abort && !last_s) begin
                        e_fin = 1'b1;
                        m_last = cyc + 1 + DRAIN;
                        abt_ev[m_last] = 1'b1;
                        m_mode = 2;
                    end else if (snap_valid) begin
                        e_q = snap_q; e_i = snap_i;
                        m_cnt = (m_cnt + 1) % NSAMP;
                        if (last_s) begin
                            e_fin = 1'b1;
                            m_last = cyc + 1 + DRAIN;
                            cap_ev[m_last] = 1'b1;
                            m_frames--;
                            if (m_frames == 0 || abort) m_mode = 2;
                        end
                    end
                end
                default: if (cyc >= m_last) m_mode = 0;
            endcase
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_obs();
        n_fin = 0; n_cap = 0; n_fd = 0; n_abt = 0;
        fin_times.delete();
    endtask

    task automatic pulse_start(input int frames);
        cfg = FW'(frames);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int n, input bit gaps, input bit rnd);
        for (int k = 0; k < n; k++) begin
            snap_valid = 1'b1;
            snap_q = rnd ? {$urandom, $urandom} : {NA{16'sd4}};
            snap_i = rnd ? {$urandom, $urandom} : {NA{16'sd4}};
            tick();
            snap_valid = 1'b0;
            snap_q = '0;
            snap_i = '0;
            if (gaps && k != n - 1) tick();
        end
    endtask

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        while (busy_o && t < 400) begin
            tick();
            t++;
        end
        if (busy_o) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: busy still %0b after %0d cycles, required 0", nm, busy_o, t);
        end
        tick();
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // 1: one frame, back-to-back, all samples 4+4j
        clr_obs(); chk_diag = 1'b1;
        pulse_start(1);
        send(NSAMP, 1'b0, 1'b0);
        wait_idle("t1");
        chk_int("t1_latency", cap_cyc - fin_cyc, 14);
        chk_int("t1_ncap", n_cap, 1);
        chk_int("t1_nfin", n_fin, 1);

        // 2: same data, valid every other cycle
        clr_obs();
        pulse_start(1);
        send(NSAMP, 1'b1, 1'b0);
`ifdef COV_STALL_CNT_EN
        chk("t2_stall", 128'(stall_cnt_o), 128'(15));
`endif
        wait_idle("t2");
        chk_int("t2_latency", cap_cyc - fin_cyc, 14);
        chk_int("t2_ncap", n_cap, 1);

        // 3: three frames, continuous
        clr_obs();
        pulse_start(3);
        send(3 * NSAMP, 1'b0, 1'b0);
        wait_idle("t3");
        chk_int("t3_nfin", n_fin, 3);
        chk_int("t3_ncap", n_cap, 3);
        chk_int("t3_nfd", n_fd, 3);
        if (fin_times.size() == 3) begin
            chk_int("t3_spacing0", fin_times[1] - fin_times[0], 16);
            chk_int("t3_spacing1", fin_times[2] - fin_times[1], 16);
        end else begin
            chk_int("t3_fin_count", fin_times.size(), 3);
        end
        chk_int("t3_latency", cap_cyc - fin_cyc, 14);

        // 4: abort after 7 samples
        clr_obs(); chk_diag = 1'b0;
        pulse_start(1);
        send(7, 1'b0, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_idle("t4");
        chk_int("t4_ncap", n_cap, 0);
        chk_int("t4_nabt", n_abt, 1);
        chk_int("t4_abt_latency", abt_cyc - fin_cyc, 14);

        // 5: reset in the middle of FLUSH
        clr_obs();
        pulse_start(1);
        send(NSAMP, 1'b0, 1'b0);
        repeat (5) tick();
        chk("t5_in_flush", 128'(busy_o), 128'(1));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_rst_ctrl", 128'({busy_o, snap_ready_o, arr_finish_o, res_capture_o,
                                 frame_done_o, aborted_o}), 128'(0));
        chk("t5_rst_arr", {arr_q_o, arr_i_o}, 128'(0));
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk_int("t5_no_capture", n_cap, 0);

        // 6: cfg_frames = 0 behaves as one frame
        clr_obs(); chk_diag = 1'b1;
        pulse_start(0);
        send(NSAMP, 1'b0, 1'b0);
        wait_idle("t6");
        chk_int("t6_nfd", n_fd, 1);
        chk_diag = 1'b0;

        // Random runs: bubbles, aborts, stray starts, start+abort together
        for (int r = 0; r < 40; r++) begin
            abort = ($urandom_range(0, 3) == 0);
            pulse_start($urandom_range(0, 3));
            abort = 1'b0;
            for (int t = 0; t < 300 && busy_o; t++) begin
                snap_valid = ($urandom_range(0, 3) != 0);
                snap_q = {$urandom, $urandom};
                snap_i = {$urandom, $urandom};
                abort = ($urandom_range(0, 79) == 0);
                start = ($urandom_range(0, 15) == 0);
                cfg = FW'($urandom_range(0, 3));
                tick();
            end
            snap_valid = 1'b0; abort = 1'b0; start = 1'b0;
            wait_idle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
